// File: rtl/dphy_lane_sequencer.sv
// D-PHY transmit lane sequencer for a two-data-lane link: clock-lane start/stop
// and framed HS data bursts, each ending in a one-cycle end-of-command pulse.
module dphy_lane_sequencer #(
    parameter int T_LPX       = 5,
    parameter int T_CLK_PREP  = 4,
    parameter int T_CLK_ZERO  = 30,
    parameter int T_CLK_TRAIL = 6,
    parameter int T_HS_PREP   = 6,
    parameter int T_HS_ZERO   = 11,
    parameter int T_HS_TRAIL  = 7,
    parameter int T_HS_EXIT   = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_state,
    input  logic       i_valid,
    input  logic [7:0] i_byte_D1,
    input  logic [7:0] i_byte_D0,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] o_byte_D1,
    output logic [7:0] o_byte_D0,
    output logic [1:0] o_lp1_out,
    output logic [1:0] o_lp0_out,
    output logic       o_lp1_dir,
    output logic       o_lp0_dir,
    output logic       o_hs_clk_en,
    output logic       o_hsxx_clk_en,
    output logic       o_lp_clk,
    output logic       o_hs_data_en,
    output logic       o_clk_on,
    output logic       o_busy,
    output logic       o_eoc,
    output logic       o_err
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_LPX, T_CLK_PREP), max2(T_CLK_ZERO, T_CLK_TRAIL)),
                                max2(max2(T_HS_PREP, T_HS_ZERO), max2(T_HS_TRAIL, T_HS_EXIT)));
    localparam int CW = $clog2(T_MAX) + 1;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    function automatic logic [CW-1:0] dur(input int t);
        return CW'(t - 1);
    endfunction

    // Trail level is the inverse of the final driven bit on that lane.
    function automatic logic [7:0] trail_of(input logic [7:0] b);
        return {8{~b[7]}};
    endfunction

    typedef enum logic [3:0] {
        IDLE, CLK_LP01, CLK_LP00, CLK_PREP, CLK_ZERO, CLK_TRAIL,
        D_LP01, D_LP00, D_PREP, D_ZERO, D_SYNC, D_PAYLOAD, D_LAST, D_TRAIL,
        EXIT, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          underrun;

    // NOTE: every output is assigned for the state being entered, so outputs are
    // registered yet line up with the state; all state updates use <= only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            underrun      <= 1'b0;
            o_ready       <= 1'b0;
            o_byte_D1     <= '0;
            o_byte_D0     <= '0;
            o_lp1_out     <= 2'b11;
            o_lp0_out     <= 2'b11;
            o_lp1_dir     <= 1'b1;
            o_lp0_dir     <= 1'b1;
            o_hs_clk_en   <= 1'b0;
            o_hsxx_clk_en <= 1'b0;
            o_lp_clk      <= 1'b1;
            o_hs_data_en  <= 1'b0;
            o_clk_on      <= 1'b0;
            o_busy        <= 1'b0;
            o_eoc         <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_eoc <= 1'b0;
            o_err <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;

            case (state)
                IDLE: if (i_start) begin
                    o_busy <= 1'b1;
                    if (i_state && !o_clk_on) begin
                        state         <= CLK_LP01;
                        cnt           <= dur(T_LPX);
                        o_lp_clk      <= 1'b0;
                        o_hsxx_clk_en <= 1'b1;
                    end else if (i_state) begin
                        state <= CLK_TRAIL;
                        cnt   <= dur(T_CLK_TRAIL);
                    end else if (!o_clk_on) begin
                        state <= DONE;
                        o_eoc <= 1'b1;
                        o_err <= 1'b1;
                    end else begin
                        state     <= D_LP01;
                        cnt       <= dur(T_LPX);
                        o_lp1_out <= 2'b01;
                        o_lp0_out <= 2'b01;
                    end
                end
                CLK_LP01: if (cnt == '0) begin
                    state         <= CLK_LP00;
                    cnt           <= dur(T_LPX);
                    o_hsxx_clk_en <= 1'b0;
                end
                CLK_LP00: if (cnt == '0) begin
                    state       <= CLK_PREP;
                    cnt         <= dur(T_CLK_PREP);
                    o_hs_clk_en <= 1'b1;
                end
                CLK_PREP: if (cnt == '0) begin
                    state <= CLK_ZERO;
                    cnt   <= dur(T_CLK_ZERO);
                end
                CLK_ZERO: if (cnt == '0) begin
                    state    <= DONE;
                    o_eoc    <= 1'b1;
                    o_clk_on <= 1'b1;
                end
                CLK_TRAIL: if (cnt == '0) begin
                    state       <= EXIT;
                    cnt         <= dur(T_HS_EXIT);
                    o_hs_clk_en <= 1'b0;
                    o_lp_clk    <= 1'b1;
                end
                D_LP01: if (cnt == '0) begin
                    state     <= D_LP00;
                    cnt       <= dur(T_LPX);
                    o_lp1_out <= 2'b00;
                    o_lp0_out <= 2'b00;
                end
                D_LP00: if (cnt == '0) begin
                    state        <= D_PREP;
                    cnt          <= dur(T_HS_PREP);
                    o_hs_data_en <= 1'b1;
                    o_byte_D1    <= '0;
                    o_byte_D0    <= '0;
                end
                D_PREP: if (cnt == '0) begin
                    state <= D_ZERO;
                    cnt   <= dur(T_HS_ZERO);
                end
                D_ZERO: if (cnt == '0) begin
                    state     <= D_SYNC;
                    o_byte_D1 <= SYNC_BYTE;
                    o_byte_D0 <= SYNC_BYTE;
                end
                D_SYNC: begin
                    state   <= D_PAYLOAD;
                    o_ready <= 1'b1;
                end
                D_PAYLOAD: if (i_valid) begin
                    o_byte_D1 <= i_byte_D1;
                    o_byte_D0 <= i_byte_D0;
                    if (i_last) begin
                        state   <= D_LAST;
                        o_ready <= 1'b0;
                    end
                end else begin
                    state     <= D_TRAIL;
                    cnt       <= dur(T_HS_TRAIL);
                    underrun  <= 1'b1;
                    o_ready   <= 1'b0;
                    o_byte_D1 <= trail_of(o_byte_D1);
                    o_byte_D0 <= trail_of(o_byte_D0);
                end
                D_LAST: begin
                    state     <= D_TRAIL;
                    cnt       <= dur(T_HS_TRAIL);
                    o_byte_D1 <= trail_of(o_byte_D1);
                    o_byte_D0 <= trail_of(o_byte_D0);
                end
                D_TRAIL: if (cnt == '0) begin
                    state        <= EXIT;
                    cnt          <= dur(T_HS_EXIT);
                    o_hs_data_en <= 1'b0;
                    o_lp1_out    <= 2'b11;
                    o_lp0_out    <= 2'b11;
                    o_byte_D1    <= '0;
                    o_byte_D0    <= '0;
                end
                // Shared by burst and clock stop: the clock lane is still in HS
                // only if the HS clock was left running.
                EXIT: if (cnt == '0) begin
                    state    <= DONE;
                    o_eoc    <= 1'b1;
                    o_err    <= underrun;
                    o_clk_on <= o_hs_clk_en;
                end
                DONE: begin
                    state    <= IDLE;
                    o_busy   <= 1'b0;
                    underrun <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dphy_lane_sequencer.sv
// Self-checking bench for dphy_lane_sequencer: every cycle of each command is
// compared against a timeline model derived from the sequence durations.
module tb_dphy_lane_sequencer;

    localparam int T_LPX       = 5;
    localparam int T_CLK_PREP  = 4;
    localparam int T_CLK_ZERO  = 30;
    localparam int T_CLK_TRAIL = 6;
    localparam int T_HS_PREP   = 6;
    localparam int T_HS_ZERO   = 11;
    localparam int T_HS_TRAIL  = 7;
    localparam int T_HS_EXIT   = 10;
    localparam int P_READY     = 2*T_LPX + T_HS_PREP + T_HS_ZERO + 2;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_state = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_byte_D1 = '0;
    logic [7:0] i_byte_D0 = '0;
    logic       i_last = 1'b0;
    logic       o_ready, o_lp1_dir, o_lp0_dir, o_hs_clk_en, o_hsxx_clk_en, o_lp_clk;
    logic       o_hs_data_en, o_clk_on, o_busy, o_eoc, o_err;
    logic [7:0] o_byte_D1, o_byte_D0;
    logic [1:0] o_lp1_out, o_lp0_out;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] pay1 [8];
    logic [7:0] pay0 [8];

    typedef struct packed {
        logic       ready;
        logic [7:0] b1;
        logic [7:0] b0;
        logic [1:0] lp1;
        logic [1:0] lp0;
        logic       dir1;
        logic       dir0;
        logic       hs_clk_en;
        logic       hsxx;
        logic       lp_clk;
        logic       hs_data_en;
        logic       clk_on;
        logic       busy;
        logic       eoc;
        logic       err;
    } obs_t;

    obs_t obs;
    assign obs = {o_ready, o_byte_D1, o_byte_D0, o_lp1_out, o_lp0_out, o_lp1_dir, o_lp0_dir,
                  o_hs_clk_en, o_hsxx_clk_en, o_lp_clk, o_hs_data_en, o_clk_on, o_busy,
                  o_eoc, o_err};

    always #5 i_clk = ~i_clk;

    dphy_lane_sequencer #(
        .T_LPX(T_LPX), .T_CLK_PREP(T_CLK_PREP), .T_CLK_ZERO(T_CLK_ZERO),
        .T_CLK_TRAIL(T_CLK_TRAIL), .T_HS_PREP(T_HS_PREP), .T_HS_ZERO(T_HS_ZERO),
        .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_state(i_state),
        .i_valid(i_valid), .i_byte_D1(i_byte_D1), .i_byte_D0(i_byte_D0), .i_last(i_last),
        .o_ready(o_ready), .o_byte_D1(o_byte_D1), .o_byte_D0(o_byte_D0),
        .o_lp1_out(o_lp1_out), .o_lp0_out(o_lp0_out), .o_lp1_dir(o_lp1_dir),
        .o_lp0_dir(o_lp0_dir), .o_hs_clk_en(o_hs_clk_en), .o_hsxx_clk_en(o_hsxx_clk_en),
        .o_lp_clk(o_lp_clk), .o_hs_data_en(o_hs_data_en), .o_clk_on(o_clk_on),
        .o_busy(o_busy), .o_eoc(o_eoc), .o_err(o_err)
    );

    // Quiescent output set with the clock lane either in LP-11 or running HS.
    function automatic obs_t idle_exp(input bit c);
        obs_t e;
        e = '0;
        e.lp1 = 2'b11;
        e.lp0 = 2'b11;
        e.dir1 = 1'b1;
        e.dir0 = 1'b1;
        e.hs_clk_en = c;
        e.lp_clk = !c;
        e.clk_on = c;
        return e;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic noise();
        i_valid   = 1'($urandom);
        i_last    = 1'($urandom);
        i_state   = 1'($urandom);
        i_byte_D1 = 8'($urandom);
        i_byte_D0 = 8'($urandom);
    endtask

    task automatic test_reset();
        obs_t e;
        i_rst = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        e = idle_exp(1'b0);
        for (int t = 0; t < 100; t++) begin
            step();
            noise();
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL reset_idle t=%0d got=%h want=%h", t, obs, e);
            end
        end
    endtask

    task automatic test_burst_no_clock(input string name);
        obs_t e;
        i_start = 1'b1;
        i_state = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            step();
            i_start = 1'b0;
            noise();
            e = idle_exp(1'b0);
            if (t == 1) begin
                e.busy = 1'b1;
                e.eoc = 1'b1;
                e.err = 1'b1;
            end
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL %s t=%0d got=%h want=%h", name, t, obs, e);
            end
        end
    endtask

    task automatic test_clock_start();
        obs_t e;
        int d, stray;
        d = 2*T_LPX + T_CLK_PREP + T_CLK_ZERO + 1;
        stray = $urandom_range(d, 2);
        i_start = 1'b1;
        i_state = 1'b1;
        for (int t = 1; t <= d + 1; t++) begin
            step();
            i_start = (t == stray);
            noise();
            e = idle_exp(t >= d);
            if (t < d) begin
                e.busy = 1'b1;
                e.lp_clk = 1'b0;
                e.hsxx = (t <= T_LPX);
                e.hs_clk_en = (t > 2*T_LPX);
            end
            if (t == d) begin
                e.busy = 1'b1;
                e.eoc = 1'b1;
            end
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL clock_start t=%0d got=%h want=%h", t, obs, e);
            end
        end
        i_start = 1'b0;
    endtask

    task automatic test_clock_stop();
        obs_t e;
        int d, stray;
        d = T_CLK_TRAIL + T_HS_EXIT + 1;
        stray = $urandom_range(d, 2);
        i_start = 1'b1;
        i_state = 1'b1;
        for (int t = 1; t <= d + 1; t++) begin
            step();
            i_start = (t == stray);
            noise();
            e = idle_exp(t < d);
            if (t < d) begin
                e.busy = 1'b1;
                if (t > T_CLK_TRAIL) begin
                    e.hs_clk_en = 1'b0;
                    e.lp_clk = 1'b1;
                end
            end
            if (t == d) begin
                e.busy = 1'b1;
                e.eoc = 1'b1;
            end
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL clock_stop t=%0d got=%h want=%h", t, obs, e);
            end
        end
        i_start = 1'b0;
    endtask

    // m pairs are accepted from pay1/pay0; with underrun the cycle after them has
    // i_valid low, otherwise pair m-1 carries i_last.
    task automatic run_burst(input string name, input int m, input bit underrun);
        obs_t e;
        int s, x, d, rdy_end, stray;
        logic [7:0] l1, l0;
        s = P_READY + m + 1;
        x = s + T_HS_TRAIL;
        d = x + T_HS_EXIT;
        rdy_end = underrun ? P_READY + m : P_READY + m - 1;
        l1 = (m == 0) ? 8'hB8 : pay1[m-1];
        l0 = (m == 0) ? 8'hB8 : pay0[m-1];
        stray = $urandom_range(d, 2);
        i_start = 1'b1;
        i_state = 1'b0;
        for (int t = 1; t <= d + 1; t++) begin
            step();
            i_start = (t == stray);
            e = idle_exp(1'b1);
            if (t <= d) e.busy = 1'b1;
            if (t <= T_LPX) begin
                e.lp1 = 2'b01;
                e.lp0 = 2'b01;
            end else if (t < x) begin
                e.lp1 = 2'b00;
                e.lp0 = 2'b00;
            end
            if (t > 2*T_LPX && t < x) begin
                e.hs_data_en = 1'b1;
                if (t < P_READY - 1) begin
                    e.b1 = 8'h00;
                    e.b0 = 8'h00;
                end else if (t <= P_READY) begin
                    e.b1 = 8'hB8;
                    e.b0 = 8'hB8;
                end else if (t <= P_READY + m) begin
                    e.b1 = pay1[t-P_READY-1];
                    e.b0 = pay0[t-P_READY-1];
                end else begin
                    e.b1 = {8{~l1[7]}};
                    e.b0 = {8{~l0[7]}};
                end
            end
            e.ready = (t >= P_READY && t <= rdy_end);
            if (t == d) begin
                e.eoc = 1'b1;
                e.err = underrun;
            end
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL %s t=%0d got=%h want=%h", name, t, obs, e);
            end
            if (t >= P_READY && t < P_READY + m) begin
                i_valid   = 1'b1;
                i_byte_D1 = pay1[t-P_READY];
                i_byte_D0 = pay0[t-P_READY];
                i_last    = !underrun && (t == P_READY + m - 1);
            end else if (underrun && t == P_READY + m) begin
                noise();
                i_valid = 1'b0;
            end else begin
                noise();
            end
        end
        i_start = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic test_random_bursts();
        obs_t e;
        int m, gap;
        bit ur;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++) begin
                pay1[k] = 8'($urandom);
                pay0[k] = 8'($urandom);
            end
            ur = 1'($urandom);
            m = ur ? $urandom_range(6, 0) : $urandom_range(6, 1);
            gap = $urandom_range(3, 0);
            e = idle_exp(1'b1);
            for (int g = 0; g < gap; g++) begin
                step();
                noise();
                tests_run++;
                if (obs !== e) begin
                    tests_failed++;
                    $display("FAIL burst_gap n=%0d got=%h want=%h", n, obs, e);
                end
            end
            run_burst("random_burst", m, ur);
        end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        i_start = 1'b1;
        i_state = 1'b0;
        i_valid = 1'b0;
        for (int t = 1; t <= P_READY; t++) begin
            step();
            i_start = 1'b0;
        end
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_ready got=%b want=1", o_ready);
        end
        i_valid = 1'b1;
        i_last = 1'b0;
        i_byte_D1 = 8'h5A;
        i_byte_D0 = 8'hA5;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_valid = 1'b0;
        e = idle_exp(1'b0);
        for (int t = 0; t < 2; t++) begin
            tests_run++;
            if (obs !== e) begin
                tests_failed++;
                $display("FAIL reset_mid t=%0d got=%h want=%h", t, obs, e);
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        step();
        test_burst_no_clock("burst_no_clock");
        test_clock_start();

        pay1[0] = 8'hA1; pay0[0] = 8'hA0;
        pay1[1] = 8'hB1; pay0[1] = 8'hB0;
        pay1[2] = 8'h41; pay0[2] = 8'h40;
        run_burst("burst3", 3, 1'b0);

        pay1[0] = 8'hC3; pay0[0] = 8'h3C;
        run_burst("underrun", 1, 1'b1);
        run_burst("underrun_first", 0, 1'b1);

        test_random_bursts();
        test_reset_mid();
        test_clock_start();
        test_clock_stop();
        test_burst_no_clock("burst_after_stop");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dphy_lane_sequencer.md
# dphy_lane_sequencer

Sits directly downstream of the initial-command timer and drives the D-PHY transmit lane controls for a two-data-lane link. Each `i_start`/`i_state` command it receives is one of three sequences:
- clock-lane start-up;
- clock-lane stop;
- one HS data burst. The burst takes a byte-pair payload over a valid/ready handshake, frames it with LP→HS entry, sync and HS trail/exit, and pulses `o_eoc` back to the timer.

## Interface
Parameters (all in `i_clk` cycles, each ≥1):
- T_LPX, 5, duration of each LP-01 and LP-00 request state
- T_CLK_PREP, 4, clock-lane HS-prepare duration
- T_CLK_ZERO, 30, clock-lane HS-zero duration
- T_CLK_TRAIL, 6, clock-lane HS-trail duration
- T_HS_PREP, 6, data-lane HS-prepare duration
- T_HS_ZERO, 11, data-lane HS-zero duration
- T_HS_TRAIL, 7, data-lane HS-trail duration
- T_HS_EXIT, 10, LP-11 hold after a burst or a clock stop, before `o_eoc`

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  sequencer clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  command strobe, one cycle
- i_state  in  1  command type: 1 = clock start/stop (toggles the clock lane), 0 = HS data burst
- i_valid  in  1  payload byte pair valid
- i_byte_D1  in  8  payload byte, lane 1
- i_byte_D0  in  8  payload byte, lane 0
- i_last  in  1  marks the final payload pair
- o_ready  out  1  payload accepted when i_valid & o_ready
- o_byte_D1, o_byte_D0  out  8 each  HS byte to the serializer
- o_lp1_out, o_lp0_out  out  2 each  data-lane LP drive {P,N}
- o_lp1_dir, o_lp0_dir  out  1 each  lane direction, 1 = transmit
- o_hs_clk_en  out  1  HS clock toggling enabled
- o_hsxx_clk_en  out  1  clock-lane LP-01 request drive
- o_lp_clk  out  1  clock-lane LP-11 drive
- o_hs_data_en  out  1  HS data serializer enable
- o_clk_on  out  1  clock lane is in HS
- o_busy  out  1  a sequence is in progress
- o_eoc  out  1  end of command, one-cycle pulse
- o_err  out  1  error, one-cycle pulse, coincident with o_eoc

## Operation
- All outputs are registered.
- Reset values:
  - o_lp1_out = o_lp0_out = 2'b11
  - o_lp1_dir = o_lp0_dir = 1
  - o_lp_clk = 1
  - all other outputs 0
  - FSM in IDLE; clock-on flag cleared
- `i_start` is honoured only in IDLE. A strobe in any other state is ignored.
- Clock start (`i_state`=1 while o_clk_on=0):
  - CLK_LP01 (o_lp_clk=0, o_hsxx_clk_en=1)
  - → CLK_LP00 (both 0)
  - → CLK_PREP (o_hs_clk_en=1)
  - → CLK_ZERO
  - → DONE; o_clk_on=1 from DONE onward
  - o_hs_clk_en stays 1 after DONE.
- Clock stop (`i_state`=1 while o_clk_on=1):
  - CLK_TRAIL (o_hs_clk_en still 1)
  - → EXIT (o_hs_clk_en=0, o_lp_clk=1)
  - → DONE; o_clk_on cleared
- Burst while o_clk_on=0: go straight to DONE with o_err=1. Lane outputs do not change.
- Burst while o_clk_on=1:
  - D_LP01 (lp*_out=2'b01) → D_LP00 (2'b00) → D_PREP → D_ZERO
  - o_hs_data_en=1 from D_PREP on; bytes are 8'h00 in D_PREP and D_ZERO.
  - D_SYNC: one cycle, both bytes = 8'hB8.
  - D_PAYLOAD: o_ready=1.
    - Each accepted pair is driven on o_byte_D1/D0 the next cycle.
    - An accepted pair with i_last → D_TRAIL.
    - A cycle in D_PAYLOAD with i_valid=0 is an underrun: → D_TRAIL, and o_err is pulsed at DONE.
  - D_TRAIL: each lane byte = {8{~b7}}, where b7 is bit 7 of that lane's last driven byte.
  - EXIT: o_hs_data_en=0, lp*_out=2'b11.
  - → DONE.
- DONE lasts one cycle: o_eoc=1, then IDLE.
- o_busy=1 in every state except IDLE.
- Duration counter:
  - one shared down-counter, width clog2(max parameter)+1;
  - loaded with T−1 on state entry, exits at 0;
  - every timed state lasts exactly T cycles.
- Reset mid-sequence: the next cycle returns every output to its reset value and clears o_clk_on. No trail is emitted.

## Timing
- `i_start` sampled high at cycle N → first sequence state outputs visible at N+1.
- Clock start: o_eoc at N + 2·T_LPX + T_CLK_PREP + T_CLK_ZERO + 1.
- Clock stop: o_eoc at N + T_CLK_TRAIL + T_HS_EXIT + 1.
- Burst entry: o_ready first high at N + 2·T_LPX + T_HS_PREP + T_HS_ZERO + 2.
- Burst exit: the last payload is driven one cycle after acceptance; trail begins the cycle after that.
- Burst-without-clock error: o_eoc and o_err at N+1.
- Earliest next command: `i_start` is accepted again in the cycle after o_eoc.

## Test plan
- Reset released, no stimulus → o_lp*_out=2'b11, o_lp_clk=1, all enables 0, o_busy=0 for 100 cycles.
- Clock start with default parameters → o_hsxx_clk_en high for cycles N+1..N+5, o_hs_clk_en rising at N+11, o_eoc pulse at N+45, o_clk_on=1.
- Burst of 3 pairs (D1/D0 = A1/A0, B1/B0, 41/40; last pair carries i_last) → sequence 00…, B8/B8, A1/A0, B1/B0, 41/40, then 7 cycles of FF/FF, 10 cycles of LP-11, o_eoc, o_err=0.
- Burst issued before clock start → o_eoc=o_err=1 at N+1, lanes stay LP-11.
- i_valid dropped after the 1st payload pair → trail starts, o_err=1 with o_eoc; second i_start issued during the burst is ignored.
- i_rst asserted during D_PAYLOAD, then clock stop after clock start → outputs at reset values one cycle later; clock stop drives o_hs_clk_en low after 6 trail cycles and o_eoc 17 cycles after i_start.
